// File: rtl/accum_sched_pkg.sv
// Shared types and the modulo-add helper for the accumulator scheduler.
// Used by both the RTL datapath and the testbench scoreboard.
package accum_sched_pkg;

    typedef enum logic [1:0] {ST_OK, ST_WRAP, ST_ERR} status_e;

    localparam int MOD_W = 32;

    typedef struct packed {
        logic             wrap;
        logic             err;
        logic [MOD_W-1:0] value;
    } mod_res_t;

    // Sum is formed one bit wider than the operands so the compare against m never sees a truncated value.
    function automatic mod_res_t mod_add(input logic [MOD_W-1:0] acc,
                                         input logic [MOD_W-1:0] d,
                                         input logic [MOD_W-1:0] m);
        logic [MOD_W:0] sum;
        mod_res_t       r;
        sum     = {1'b0, acc} + {1'b0, d};
        r.wrap  = 1'b0;
        r.err   = 1'b0;
        r.value = acc;
        if (d >= m) begin
            r.err = 1'b1;
        end else if (sum >= {1'b0, m}) begin
            r.wrap  = 1'b1;
            r.value = MOD_W'(sum - {1'b0, m});
        end else begin
            r.value = sum[MOD_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
// Pointer resets to N-1 so requester 0 wins first.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    output logic [N-1:0]  gnt_o,
    output logic [CW-1:0] gntIdx_o
);

    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;
    logic [CW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o    = '0;
        gntIdx_o = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= N; k++) begin
            cand = CW'((32'(ptr_q) + 32'(k)) % 32'(N));
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                gntIdx_o    = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = gntIdx_o;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= CW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/accum_rr_sched.sv
// N modulo-M accumulators time-sharing one adder behind a round-robin arbiter.
// Each granted update yields a registered result record one cycle later.
module accum_rr_sched
    import accum_sched_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int M  = 100,
    localparam int W  = $clog2(M),
    localparam int CW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_d,
    output logic [N-1:0]   req_ready,
    input  logic           clr_valid,
    input  logic [CW-1:0]  clr_ch,
    output logic           out_valid,
    output logic [CW-1:0]  out_ch,
    output logic [W-1:0]   out_acc,
    output logic           out_wrap,
    output logic           out_err,
    output logic [N*W-1:0] acc_all
);

    logic [W-1:0]  acc_q [N];
    logic [W-1:0]  acc_d [N];
    logic [N-1:0]  clrMask;
    logic [N-1:0]  eligible;
    logic [N-1:0]  gnt;
    logic [CW-1:0] gntIdx;
    logic          grantValid;
    logic [W-1:0]  accSel;
    logic [W-1:0]  addend;
    mod_res_t      modRes;
    logic          unusedValueHi;

    logic          outValid_q;
    logic [CW-1:0] outCh_q;
    logic [W-1:0]  outAcc_q;
    logic          outWrap_q;
    logic          outErr_q;

    // A channel being cleared is held off this cycle so its request survives to a later one.
    always_comb begin
        clrMask = '0;
        for (int c = 0; c < N; c++) begin
            clrMask[c] = clr_valid && (32'(clr_ch) == 32'(c));
        end
    end

    assign eligible = req_valid & ~clrMask & {N{~rst}};

    rr_arbiter #(.N(N)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (eligible),
        .advance_i (~rst),
        .gnt_o     (gnt),
        .gntIdx_o  (gntIdx)
    );

    assign req_ready  = gnt;
    assign grantValid = |gnt;

    always_comb begin
        accSel = '0;
        addend = '0;
        for (int c = 0; c < N; c++) begin
            if (gntIdx == CW'(c)) begin
                accSel = acc_q[c];
                addend = req_d[c*W +: W];
            end
        end
    end

    assign modRes        = mod_add(32'(accSel), 32'(addend), 32'(M));
    assign unusedValueHi = ^modRes.value[MOD_W-1:W];

    always_comb begin
        for (int c = 0; c < N; c++) begin
            acc_d[c] = acc_q[c];
            if (grantValid && !modRes.err && gntIdx == CW'(c)) begin
                acc_d[c] = modRes.value[W-1:0];
            end
            if (clrMask[c]) begin
                acc_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < N; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    // Channel and value hold between results; the flags only describe the current strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outCh_q    <= '0;
            outAcc_q   <= '0;
            outWrap_q  <= 1'b0;
            outErr_q   <= 1'b0;
        end else begin
            outValid_q <= grantValid;
            outWrap_q  <= grantValid & modRes.wrap;
            outErr_q   <= grantValid & modRes.err;
            if (grantValid) begin
                outCh_q  <= gntIdx;
                outAcc_q <= modRes.value[W-1:0];
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_ch    = outCh_q;
    assign out_acc   = outAcc_q;
    assign out_wrap  = outWrap_q;
    assign out_err   = outErr_q;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign acc_all[g*W +: W] = acc_q[g];
    end

endmodule

// File: tb/tb_accum_rr_sched.sv
// Randomized and directed bench for accum_rr_sched against a plain-arithmetic
// scoreboard of N modulo-M accumulators with round-robin service.
module tb_accum_rr_sched;
    import accum_sched_pkg::*;

    localparam int N  = 4;
    localparam int M  = 100;
    localparam int W  = 7;
    localparam int CW = 2;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_d;
    logic [N-1:0]   req_ready;
    logic           clr_valid;
    logic [CW-1:0]  clr_ch;
    logic           out_valid;
    logic [CW-1:0]  out_ch;
    logic [W-1:0]   out_acc;
    logic           out_wrap;
    logic           out_err;
    logic [N*W-1:0] acc_all;

    accum_rr_sched #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_d     (req_d),
        .req_ready (req_ready),
        .clr_valid (clr_valid),
        .clr_ch    (clr_ch),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_acc   (out_acc),
        .out_wrap  (out_wrap),
        .out_err   (out_err),
        .acc_all   (acc_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       mAcc [N];
    int       mPtr;
    bit       expValid;
    int       expCh;
    int       expAcc;
    status_e  expSt;
    logic [N-1:0] lastReady;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] packD(input int d0, input int d1, input int d2, input int d3);
        return {W'(d3), W'(d2), W'(d1), W'(d0)};
    endfunction

    // One clock cycle: drive, check the grant mid-cycle, then check the record after the edge.
    task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] d,
                                 input logic cv, input logic [CW-1:0] cc, input logic r);
        logic [N-1:0] elig;
        logic [N-1:0] expReady;
        int           g;
        int           c;
        int           dv;
        req_valid = v;
        req_d     = d;
        clr_valid = cv;
        clr_ch    = cc;
        rst       = r;
        @(negedge clk);
        elig = r ? '0 : v;
        if (cv && int'(cc) < N) elig[cc] = 1'b0;
        g = -1;
        for (int k = 1; k <= N; k++) begin
            c = (mPtr + k) % N;
            if (g < 0 && elig[c]) g = c;
        end
        expReady = '0;
        if (g >= 0) expReady[g] = 1'b1;
        lastReady = req_ready;
        checkOutput("req_ready", 64'(req_ready), 64'(expReady));
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < N; i++) mAcc[i] = 0;
            mPtr     = N - 1;
            expValid = 1'b0;
        end else begin
            if (cv && int'(cc) < N) mAcc[cc] = 0;
            expValid = (g >= 0);
            if (g >= 0) begin
                dv = int'(d[g*W +: W]);
                if (dv >= M) begin
                    expSt = ST_ERR;
                end else if (mAcc[g] + dv >= M) begin
                    expSt   = ST_WRAP;
                    mAcc[g] = mAcc[g] + dv - M;
                end else begin
                    expSt   = ST_OK;
                    mAcc[g] = mAcc[g] + dv;
                end
                expCh  = g;
                expAcc = mAcc[g];
                mPtr   = g;
            end
        end
        checkOutput("out_valid", 64'(out_valid), 64'(expValid));
        if (expValid) begin
            checkOutput("out_ch", 64'(out_ch), 64'(expCh));
            checkOutput("out_acc", 64'(out_acc), 64'(expAcc));
            checkOutput("out_wrap", 64'(out_wrap), 64'(expSt == ST_WRAP));
            checkOutput("out_err", 64'(out_err), 64'(expSt == ST_ERR));
        end
        for (int i = 0; i < N; i++) begin
            checkOutput("acc_all", 64'(acc_all[i*W +: W]), 64'(mAcc[i]));
        end
    endtask

    initial begin
        logic [N-1:0]   rv;
        logic [N*W-1:0] rd;
        logic           rcv;
        logic [CW-1:0]  rcc;
        logic           rr;
        mPtr      = N - 1;
        for (int i = 0; i < N; i++) mAcc[i] = 0;
        expValid  = 1'b0;
        expCh     = 0;
        expAcc    = 0;
        expSt     = ST_OK;
        req_valid = '0;
        req_d     = '0;
        clr_valid = 1'b0;
        clr_ch    = '0;
        rst       = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus('0, '0, 1'b0, '0, 1'b1);
        applyStimulus(4'b1111, packD(1, 1, 1, 1), 1'b0, '0, 1'b1);
        checkOutput("rst_ready", 64'(lastReady), 64'(0));
        checkOutput("rst_acc_all", 64'(acc_all), 64'(0));
        checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
        applyStimulus('0, '0, 1'b0, '0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0001, packD(30, 0, 0, 0), 1'b0, '0, 1'b0);
            checkOutput("ch0_wrap", 64'(out_wrap), 64'(i == 3));
        end
        checkOutput("ch0_acc4", 64'(out_acc), 64'(20));

        applyStimulus('0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, packD(1, 2, 3, 4), 1'b0, '0, 1'b0);
            checkOutput("rr_order", 64'(out_ch), 64'(i % N));
        end
        checkOutput("rr_acc_all", 64'(acc_all), 64'({7'd8, 7'd6, 7'd4, 7'd2}));

        applyStimulus('0, '0, 1'b0, '0, 1'b1);
        applyStimulus(4'b0010, packD(0, 99, 0, 0), 1'b0, '0, 1'b0);
        applyStimulus(4'b0010, packD(0, 99, 0, 0), 1'b0, '0, 1'b0);
        checkOutput("ch1_acc98", 64'(out_acc), 64'(98));
        checkOutput("ch1_wrap", 64'(out_wrap), 64'(1));
        applyStimulus(4'b0010, packD(0, 127, 0, 0), 1'b0, '0, 1'b0);
        checkOutput("ch1_err", 64'(out_err), 64'(1));
        checkOutput("ch1_err_acc", 64'(out_acc), 64'(98));
        checkOutput("ch1_err_ready", 64'(lastReady), 64'(4'b0010));

        applyStimulus(4'b0100, packD(0, 0, 5, 0), 1'b0, '0, 1'b0);
        applyStimulus(4'b1100, packD(0, 0, 7, 9), 1'b1, 2'd2, 1'b0);
        checkOutput("clr_ready", 64'(lastReady), 64'(4'b1000));
        checkOutput("clr_out_ch", 64'(out_ch), 64'(3));
        checkOutput("clr_acc2", 64'(acc_all[2*W +: W]), 64'(0));
        applyStimulus(4'b0100, packD(0, 0, 7, 0), 1'b0, '0, 1'b0);
        checkOutput("clr_pending", 64'(lastReady), 64'(4'b0100));
        checkOutput("clr_pending_acc", 64'(out_acc), 64'(7));

        applyStimulus(4'b1111, packD(3, 3, 3, 3), 1'b0, '0, 1'b1);
        checkOutput("rstmid_valid", 64'(out_valid), 64'(0));
        checkOutput("rstmid_acc", 64'(acc_all), 64'(0));
        applyStimulus(4'b1111, packD(3, 3, 3, 3), 1'b0, '0, 1'b0);
        checkOutput("rstmid_first", 64'(lastReady), 64'(4'b0001));

        for (int n = 0; n < 400; n++) begin
            rv = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) rd[i*W +: W] = W'($urandom_range(M, (1 << W) - 1));
                else                           rd[i*W +: W] = W'($urandom_range(0, M - 1));
            end
            rcv = ($urandom_range(0, 5) == 0);
            rcc = CW'($urandom_range(0, N - 1));
            rr  = ($urandom_range(0, 59) == 0);
            applyStimulus(rv, rd, rcv, rcc, rr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
